// File: rtl/benes_subperm_if.sv
// Handshake and data bundle for benes_subperm.
//   start          run request (master -> slave)
//   mp0..mp7       destination output port of each input port; bit 3 must be 0
//   ci, co         input / output colour tables, 1 = Upper, 0 = Lower
//   sw_in, sw_out  outer switch settings, 0 = bar, 1 = cross
//   up0..up3       upper sub-network permutation
//   lo0..lo3       lower sub-network permutation
//   busy, done     run status; done is a one-cycle pulse
//   err            sticky error bits {range, dup, match, pair}
interface benes_subperm_if;
  logic       start;
  logic [3:0] mp0, mp1, mp2, mp3, mp4, mp5, mp6, mp7;
  logic [7:0] ci;
  logic [7:0] co;
  logic [3:0] sw_in;
  logic [3:0] sw_out;
  logic [1:0] up0, up1, up2, up3;
  logic [1:0] lo0, lo1, lo2, lo3;
  logic       busy;
  logic       done;
  logic [3:0] err;

  modport master (
    output start, mp0, mp1, mp2, mp3, mp4, mp5, mp6, mp7, ci, co,
    input  sw_in, sw_out, up0, up1, up2, up3, lo0, lo1, lo2, lo3, busy, done, err
  );

  modport slave (
    input  start, mp0, mp1, mp2, mp3, mp4, mp5, mp6, mp7, ci, co,
    output sw_in, sw_out, up0, up1, up2, up3, lo0, lo1, lo2, lo3, busy, done, err
  );
endinterface

// File: rtl/benes_subperm.sv
// Outer-stage settings generator for an 8-port Benes network.
// Scans the eight input ports one per cycle, derives the outer input/output switch settings
// and the two 4-port sub-permutations for the middle sub-networks, and flags colouring
// inconsistencies as sticky error bits.
//   clk     rising-edge clock
//   areset  asynchronous active-high reset
//   bus     benes_subperm_if slave modport (start, mp*, ci, co in; results and status out)
module benes_subperm (
  input logic             clk,
  input logic             areset,
  benes_subperm_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StScan, StCheck, StDone} state_e;

  state_e state_q, state_d;

  // start is registered so that LOAD is entered one edge after start is sampled.
  logic start_q, start_d;

  logic [7:0][3:0] mp_q, mp_d;
  logic [7:0]      ci_q, ci_d;
  logic [7:0]      co_q, co_d;
  logic [2:0]      p_q, p_d;
  logic [3:0]      used_up_q, used_up_d;
  logic [3:0]      used_lo_q, used_lo_d;

  logic [3:0]      sw_in_q, sw_in_d;
  logic [3:0]      sw_out_q, sw_out_d;
  logic [3:0][1:0] up_q, up_d;
  logic [3:0][1:0] lo_q, lo_d;
  logic [3:0]      err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Per-port scan view of the latched tables.
  logic [3:0] cur_mp;
  logic       cur_c;
  logic [2:0] cur_d;
  logic [1:0] cur_sub;
  logic [1:0] cur_k;
  logic       cur_partner_c;
  logic       cur_co_self;
  logic       cur_co_dest;
  logic [3:0] co_pair_eq;

  always_comb begin
    cur_mp        = mp_q[p_q];
    cur_c         = ci_q[p_q];
    cur_d         = cur_mp[2:0];
    cur_sub       = cur_d[2:1];
    cur_k         = p_q[2:1];
    // Colour of the odd port sharing this input switch.
    cur_partner_c = ci_q[{p_q[2:1], 1'b1}];
    cur_co_self   = co_q[p_q];
    cur_co_dest   = co_q[cur_d];
  end

  // Both ports of output switch k carrying the same colour is a pairing error.
  assign co_pair_eq = {co_q[6], co_q[4], co_q[2], co_q[0]} ~^
                      {co_q[7], co_q[5], co_q[3], co_q[1]};

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_q) state_d = StLoad;
      StLoad:  state_d = StScan;
      StScan:  if (p_q == 3'd7) state_d = StCheck;
      StCheck: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next state.
  always_comb begin
    start_d   = bus.start & (state_q == StIdle);
    mp_d      = mp_q;
    ci_d      = ci_q;
    co_d      = co_q;
    p_d       = p_q;
    used_up_d = used_up_q;
    used_lo_d = used_lo_q;
    sw_in_d   = sw_in_q;
    sw_out_d  = sw_out_q;
    up_d      = up_q;
    lo_d      = lo_q;
    err_d     = err_q;

    unique case (state_q)
      StLoad: begin
        mp_d      = {bus.mp7, bus.mp6, bus.mp5, bus.mp4, bus.mp3, bus.mp2, bus.mp1, bus.mp0};
        ci_d      = bus.ci;
        co_d      = bus.co;
        p_d       = 3'd0;
        used_up_d = 4'd0;
        used_lo_d = 4'd0;
        err_d     = 4'd0;
      end
      StScan: begin
        // Counter saturates at 7; the FSM leaves SCAN on that cycle.
        if (p_q != 3'd7) p_d = p_q + 3'd1;
        if (cur_mp[3]) begin
          err_d[3] = 1'b1;
        end else begin
          if (cur_co_dest != cur_c) err_d[1] = 1'b1;
          if (cur_c) begin
            up_d[cur_k] = cur_sub;
            if (used_up_q[cur_sub]) err_d[2] = 1'b1;
            used_up_d[cur_sub] = 1'b1;
          end else begin
            lo_d[cur_k] = cur_sub;
            if (used_lo_q[cur_sub]) err_d[2] = 1'b1;
            used_lo_d[cur_sub] = 1'b1;
          end
          if (!p_q[0]) begin
            sw_in_d[cur_k]  = ~cur_c;
            sw_out_d[cur_k] = ~cur_co_self;
            if (cur_c == cur_partner_c) err_d[0] = 1'b1;
          end
        end
      end
      StCheck: begin
        if (|co_pair_eq) err_d[0] = 1'b1;
      end
      default: ;
    endcase
  end

  // Status flags follow the upcoming state so they are registered, not decoded.
  always_comb begin
    busy_d = (state_d == StLoad) || (state_d == StScan) || (state_d == StCheck);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      mp_q      <= '0;
      ci_q      <= 8'd0;
      co_q      <= 8'd0;
      p_q       <= 3'd0;
      used_up_q <= 4'd0;
      used_lo_q <= 4'd0;
      sw_in_q   <= 4'd0;
      sw_out_q  <= 4'd0;
      up_q      <= '0;
      lo_q      <= '0;
      err_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      mp_q      <= mp_d;
      ci_q      <= ci_d;
      co_q      <= co_d;
      p_q       <= p_d;
      used_up_q <= used_up_d;
      used_lo_q <= used_lo_d;
      sw_in_q   <= sw_in_d;
      sw_out_q  <= sw_out_d;
      up_q      <= up_d;
      lo_q      <= lo_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sw_in  = sw_in_q;
  assign bus.sw_out = sw_out_q;
  assign bus.up0    = up_q[0];
  assign bus.up1    = up_q[1];
  assign bus.up2    = up_q[2];
  assign bus.up3    = up_q[3];
  assign bus.lo0    = lo_q[0];
  assign bus.lo1    = lo_q[1];
  assign bus.lo2    = lo_q[2];
  assign bus.lo3    = lo_q[3];
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_benes_subperm.sv
// Table-driven bench for benes_subperm: directed vectors with hand-computed results, plus
// sequences for reset mid-run and start pulses while busy.
module tb_benes_subperm;

  logic clk;
  logic areset;
  int   cyc = 0;
  int   c0  = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  benes_subperm_if bus ();

  benes_subperm dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] mp;      // nibble i = mp_i
    logic [7:0]  ci;
    logic [7:0]  co;
    logic        chk_res; // results only meaningful when err is zero
    logic [3:0]  sw_in;
    logic [3:0]  sw_out;
    logic [7:0]  up;      // {up3, up2, up1, up0}
    logic [7:0]  lo;      // {lo3, lo2, lo1, lo0}
    logic [3:0]  err;
  } vec_t;

  localparam int NumVec = 9;
  vec_t vecs [NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [31:0] m;
    m = v.mp;
    bus.mp0 = m[3:0];   bus.mp1 = m[7:4];   bus.mp2 = m[11:8];  bus.mp3 = m[15:12];
    bus.mp4 = m[19:16]; bus.mp5 = m[23:20]; bus.mp6 = m[27:24]; bus.mp7 = m[31:28];
    bus.ci  = v.ci;
    bus.co  = v.co;
  endtask

  function automatic logic [7:0] up_all();
    return {bus.up3, bus.up2, bus.up1, bus.up0};
  endfunction

  function automatic logic [7:0] lo_all();
    return {bus.lo3, bus.lo2, bus.lo1, bus.lo0};
  endfunction

  // Leaves the bench at the negedge following edge 0 (start sampled at edge 0).
  task automatic kick();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c0 = cyc;
  endtask

  // Returns edges from edge 0 to the first observed done, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        lat = cyc - c0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_results(input string tag, input vec_t v);
    check({tag, " err"}, 32'(bus.err), 32'(v.err));
    if (v.chk_res) begin
      check({tag, " sw_in"},  32'(bus.sw_in),  32'(v.sw_in));
      check({tag, " sw_out"}, 32'(bus.sw_out), 32'(v.sw_out));
      check({tag, " up"},     32'(up_all()),   32'(v.up));
      check({tag, " lo"},     32'(lo_all()),   32'(v.lo));
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    apply(v);
    kick();
    check({tag, " busy_e0"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({tag, " busy_e1"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), 32'd11);
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    check_results(tag, v);
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " sw_in"},  32'(bus.sw_in),  32'd0);
    check({tag, " sw_out"}, 32'(bus.sw_out), 32'd0);
    check({tag, " up"},     32'(up_all()),   32'd0);
    check({tag, " lo"},     32'(lo_all()),   32'd0);
    check({tag, " err"},    32'(bus.err),    32'd0);
    check({tag, " busy"},   32'(bus.busy),   32'd0);
    check({tag, " done"},   32'(bus.done),   32'd0);
  endtask

  initial begin
    int lat;
    int extra_done;

    // mp, ci, co, chk_res, sw_in, sw_out, up, lo, err
    vecs[0] = '{32'h76543210, 8'h55, 8'h55, 1'b1, 4'b0000, 4'b0000, 8'hE4, 8'hE4, 4'b0000};
    vecs[1] = '{32'h01234567, 8'h55, 8'hAA, 1'b1, 4'b0000, 4'b1111, 8'h1B, 8'h1B, 4'b0000};
    vecs[2] = '{32'h76543210, 8'h55, 8'hAA, 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b0010};
    vecs[3] = '{32'h76543210, 8'h0F, 8'h55, 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b0111};
    vecs[4] = '{32'h76543010, 8'h55, 8'h55, 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b0100};
    vecs[5] = '{32'h76D43210, 8'h55, 8'h55, 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b1000};
    vecs[6] = '{32'h76543210, 8'hAA, 8'hAA, 1'b1, 4'b1111, 4'b1111, 8'hE4, 8'hE4, 4'b0000};
    vecs[7] = '{32'h51432607, 8'h69, 8'h96, 1'b1, 4'b0110, 4'b1001, 8'h27, 8'h9C, 4'b0000};
    // Output pairs share a colour: pairing flagged only at CHECK, plus duplicate subs.
    vecs[8] = '{32'h73625140, 8'h55, 8'h0F, 1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b0101};

    areset    = 1'b1;
    bus.start = 1'b0;
    apply(vecs[0]);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    areset = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
      repeat (2) @(negedge clk);
    end

    // Reset during SCAN: outputs clear at once and the run produces no done.
    apply(vecs[7]);
    kick();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 areset = 1'b1;
    #1 check_all_zero("midreset");
    extra_done = 0;
    repeat (2) @(negedge clk);
    areset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check("midreset no_done", 32'(extra_done), 32'd0);
    run_vec("after_reset", vecs[0]);
    repeat (2) @(negedge clk);

    // start pulses while busy are dropped; inputs changed after LOAD are not used.
    apply(vecs[0]);
    kick();
    @(negedge clk);            // after edge 1
    @(negedge clk);            // after edge 2
    apply(vecs[7]);
    bus.start = 1'b1;          // sampled at edge 3
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk); // after edge 6
    bus.start = 1'b1;          // sampled at edge 7
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    check("ignore latency", 32'(lat), 32'd11);
    check_results("ignore", vecs[0]);
    extra_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check("ignore single_done", 32'(extra_done), 32'd0);
    check("ignore idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
